// File: rtl/seq_game_pkg.sv
// rtl/seq_game_pkg.sv - shared types, codes and helpers for the memory-game sequence checker
//
// Purpose: state encoding for the checker FSM, the three legal thermometer codes
//          and a helper that says whether a generator value is one of them.
// Ports:   none (package).

package seq_game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SHOW,
    WAIT_IN,
    LOST,
    WON
  } state_t;

  localparam logic [2:0] CODE_A = 3'b001;
  localparam logic [2:0] CODE_B = 3'b011;
  localparam logic [2:0] CODE_C = 3'b111;

  // Takes a zero-extended code so callers with any CODE_W up to 8 can use it.
  function automatic logic is_valid_code(input logic [7:0] code);
    return (code == {5'b0, CODE_A}) ||
           (code == {5'b0, CODE_B}) ||
           (code == {5'b0, CODE_C});
  endfunction

endpackage

// File: rtl/seq_recall_checker_if.sv
// rtl/seq_recall_checker_if.sv - display and player-entry handshake bundle
//
// Purpose: groups the replay stream (show_*) and the player entry strobe (player_*).
// Signals:
//   show_valid   checker -> display   code on show_code is valid
//   show_code    checker -> display   code to display, 0 when not valid
//   show_ready   display -> checker   display accepts the current code
//   player_valid front-end -> checker one-cycle player entry strobe
//   player_code  front-end -> checker player entry
// Modports: master = checker side, slave = display/button front-end side.

interface seq_recall_checker_if #(
  parameter int CODE_W = 3
);

  logic              show_valid;
  logic [CODE_W-1:0] show_code;
  logic              show_ready;
  logic              player_valid;
  logic [CODE_W-1:0] player_code;

  modport master (
    output show_valid,
    output show_code,
    input  show_ready,
    input  player_valid,
    input  player_code
  );

  modport slave (
    input  show_valid,
    input  show_code,
    output show_ready,
    output player_valid,
    output player_code
  );

endinterface

// File: rtl/seq_store.sv
// rtl/seq_store.sv - sequence register file, one synchronous write and one asynchronous read port
//
// Purpose: holds the captured code of every round played so far.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data (combinational)
// Contents are not reset; the checker never reads an entry before writing it.

module seq_store #(
  parameter int DEPTH = 16,
  parameter int W     = 3,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/seq_recall_checker.sv
// rtl/seq_recall_checker.sv - memory-game sequence capture, replay and player check
//
// Purpose: stops the LFSR generator for one cycle per round to capture a code,
//          replays the whole stored sequence to the display, then checks the
//          player's entries against it, growing the sequence one round at a time.
// Ports:
//   clk         in   clock
//   reset       in   asynchronous, active-high reset
//   start       in   begin a new game (IDLE, LOST, WON only)
//   gen_value   in   current generator code
//   gen_stop    out  generator stop, high only in CAPTURE
//   level       out  current sequence length
//   hit         out  pulse: correct non-final entry
//   round_done  out  pulse: full sequence entered correctly
//   lost        out  sticky: mismatch occurred
//   won         out  sticky: MAX_LEN rounds completed
//   busy        out  high in CAPTURE, SHOW, WAIT_IN
//   bus         master side of the display/player handshake

module seq_recall_checker
  import seq_game_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int CODE_W  = 3,
  localparam int LW     = $clog2(MAX_LEN + 1),
  localparam int IW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CODE_W-1:0]    gen_value,
  output logic                 gen_stop,
  output logic [LW-1:0]        level,
  output logic                 hit,
  output logic                 round_done,
  output logic                 lost,
  output logic                 won,
  output logic                 busy,
  seq_recall_checker_if.master bus
);

  state_t            state;
  logic [LW-1:0]     level_q;
  logic [IW-1:0]     idx;
  logic [CODE_W-1:0] capture_code;
  logic [CODE_W-1:0] stored_code;
  logic [IW-1:0]     waddr;
  logic              idx_last;
  logic              at_max;
  logic              match;

  // Anything the generator offers outside the three thermometer codes is
  // replaced by the shortest one so the display always gets a legal code.
  assign capture_code = is_valid_code(8'(gen_value)) ? gen_value : CODE_W'(CODE_A);

  // The new round's code lands in the slot just past the previous rounds.
  assign waddr    = IW'(level_q - LW'(1));
  assign idx_last = (LW'(idx) == (level_q - LW'(1)));
  assign at_max   = (level_q == LW'(MAX_LEN));
  assign match    = (bus.player_code == stored_code);

  seq_store #(
    .DEPTH (MAX_LEN),
    .W     (CODE_W),
    .AW    (IW)
  ) u_store (
    .clk   (clk),
    .we    (state == CAPTURE),
    .waddr (waddr),
    .wdata (capture_code),
    .raddr (idx),
    .rdata (stored_code)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      level_q    <= '0;
      idx        <= '0;
      hit        <= 1'b0;
      round_done <= 1'b0;
      lost       <= 1'b0;
      won        <= 1'b0;
    end else begin
      hit        <= 1'b0;
      round_done <= 1'b0;
      case (state)
        IDLE, LOST, WON: begin
          if (start) begin
            level_q <= LW'(1);
            idx     <= '0;
            lost    <= 1'b0;
            won     <= 1'b0;
            state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          idx   <= '0;
          state <= SHOW;
        end
        SHOW: begin
          if (bus.show_ready) begin
            if (idx_last) begin
              idx   <= '0;
              state <= WAIT_IN;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        WAIT_IN: begin
          // start is not looked at here, so a coincident player entry wins.
          if (bus.player_valid) begin
            if (!match) begin
              lost  <= 1'b1;
              state <= LOST;
            end else if (!idx_last) begin
              hit <= 1'b1;
              idx <= idx + IW'(1);
            end else begin
              round_done <= 1'b1;
              idx        <= '0;
              if (at_max) begin
                won   <= 1'b1;
                state <= WON;
              end else begin
                level_q <= level_q + LW'(1);
                state   <= CAPTURE;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Decoded straight from the state register so an asynchronous reset clears
  // them in the same cycle.
  assign gen_stop       = (state == CAPTURE);
  assign busy           = (state == CAPTURE) || (state == SHOW) || (state == WAIT_IN);
  assign bus.show_valid = (state == SHOW);
  assign bus.show_code  = (state == SHOW) ? stored_code : '0;
  assign level          = level_q;

endmodule

// File: tb/tb_seq_recall_checker.sv
// tb/tb_seq_recall_checker.sv - self-checking bench for seq_recall_checker

module tb_seq_recall_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] gen_value = 3'b000;
  logic       show_ready = 1'b0;
  logic       player_valid = 1'b0;
  logic [2:0] player_code = 3'b000;
  logic       use_b = 1'b0;

  always #5 clk = ~clk;

  seq_recall_checker_if #(.CODE_W(3)) bus_a ();
  seq_recall_checker_if #(.CODE_W(3)) bus_b ();

  assign bus_a.show_ready   = show_ready;
  assign bus_a.player_valid = player_valid;
  assign bus_a.player_code  = player_code;
  assign bus_b.show_ready   = show_ready;
  assign bus_b.player_valid = player_valid;
  assign bus_b.player_code  = player_code;

  logic       a_gen_stop, a_hit, a_round_done, a_lost, a_won, a_busy;
  logic [4:0] a_level;
  logic       b_gen_stop, b_hit, b_round_done, b_lost, b_won, b_busy;
  logic [1:0] b_level;

  seq_recall_checker #(.MAX_LEN(16), .CODE_W(3)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .gen_value  (gen_value),
    .gen_stop   (a_gen_stop),
    .level      (a_level),
    .hit        (a_hit),
    .round_done (a_round_done),
    .lost       (a_lost),
    .won        (a_won),
    .busy       (a_busy),
    .bus        (bus_a)
  );

  seq_recall_checker #(.MAX_LEN(2), .CODE_W(3)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .gen_value  (gen_value),
    .gen_stop   (b_gen_stop),
    .level      (b_level),
    .hit        (b_hit),
    .round_done (b_round_done),
    .lost       (b_lost),
    .won        (b_won),
    .busy       (b_busy),
    .bus        (bus_b)
  );

  // Observed outputs of whichever instance is under test.
  logic       o_gen_stop, o_show_valid, o_hit, o_round_done, o_lost, o_won, o_busy;
  logic [2:0] o_show_code;
  logic [4:0] o_level;

  always_comb begin
    o_gen_stop   = use_b ? b_gen_stop : a_gen_stop;
    o_show_valid = use_b ? bus_b.show_valid : bus_a.show_valid;
    o_show_code  = use_b ? bus_b.show_code : bus_a.show_code;
    o_hit        = use_b ? b_hit : a_hit;
    o_round_done = use_b ? b_round_done : a_round_done;
    o_lost       = use_b ? b_lost : a_lost;
    o_won        = use_b ? b_won : a_won;
    o_busy       = use_b ? b_busy : a_busy;
    o_level      = use_b ? {3'b000, b_level} : a_level;
  end

  int checks = 0;
  int failures = 0;

  // Reference model: the game sequence as the player should see it.
  logic [2:0] seq[$];
  int         max_len = 16;

  function automatic logic [2:0] norm(input logic [2:0] v);
    if (v == 3'b001 || v == 3'b011 || v == 3'b111) return v;
    return 3'b001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".gen_stop"}, 32'(o_gen_stop), 0);
    chk({tag, ".show_valid"}, 32'(o_show_valid), 0);
    chk({tag, ".show_code"}, 32'(o_show_code), 0);
    chk({tag, ".level"}, 32'(o_level), 0);
    chk({tag, ".hit"}, 32'(o_hit), 0);
    chk({tag, ".round_done"}, 32'(o_round_done), 0);
    chk({tag, ".lost"}, 32'(o_lost), 0);
    chk({tag, ".won"}, 32'(o_won), 0);
    chk({tag, ".busy"}, 32'(o_busy), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    player_valid = 1'b0;
    show_ready = 1'b0;
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    chk_all_zero("post_reset");
    seq.delete();
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    seq.delete();
  endtask

  // Called in the capture cycle; leaves the DUT in its first replay cycle.
  task automatic capture(input logic [2:0] gv);
    gen_value = gv;
    chk("cap.gen_stop", 32'(o_gen_stop), 1);
    chk("cap.busy", 32'(o_busy), 1);
    chk("cap.show_valid", 32'(o_show_valid), 0);
    chk("cap.level", 32'(o_level), 32'(seq.size() + 1));
    chk("cap.lost", 32'(o_lost), 0);
    chk("cap.won", 32'(o_won), 0);
    seq.push_back(norm(gv));
    tick();
    gen_value = 3'($urandom);
    chk("show.gen_stop", 32'(o_gen_stop), 0);
    chk("show.round_done", 32'(o_round_done), 0);
    chk("show.hit", 32'(o_hit), 0);
  endtask

  task automatic replay(input int stall_first, input int max_stall);
    int stall;
    for (int i = 0; i < seq.size(); i++) begin
      chk("replay.valid", 32'(o_show_valid), 1);
      chk("replay.code", 32'(o_show_code), 32'(seq[i]));
      chk("replay.busy", 32'(o_busy), 1);
      stall = (i == 0 && stall_first > 0) ? stall_first : int'($urandom_range(0, max_stall));
      for (int k = 0; k < stall; k++) begin
        show_ready = 1'b0;
        player_valid = 1'($urandom);
        player_code = 3'($urandom);
        start = 1'($urandom);
        tick();
        player_valid = 1'b0;
        start = 1'b0;
        chk("stall.code", 32'(o_show_code), 32'(seq[i]));
        chk("stall.valid", 32'(o_show_valid), 1);
        chk("stall.lost", 32'(o_lost), 0);
        chk("stall.level", 32'(o_level), 32'(seq.size()));
      end
      show_ready = 1'b1;
      tick();
      show_ready = 1'b0;
    end
    chk("wait.show_valid", 32'(o_show_valid), 0);
    chk("wait.show_code", 32'(o_show_code), 0);
    chk("wait.busy", 32'(o_busy), 1);
  endtask

  task automatic enter(input logic [2:0] code);
    player_code = code;
    player_valid = 1'b1;
    start = 1'($urandom);
    tick();
    player_valid = 1'b0;
    start = 1'b0;
  endtask

  // Enters the first n codes correctly; non-final entries must pulse hit.
  task automatic enter_prefix(input int n);
    for (int i = 0; i < n; i++) begin
      enter(seq[i]);
      if (i == seq.size() - 1) begin
        chk("final.round_done", 32'(o_round_done), 1);
        chk("final.hit", 32'(o_hit), 0);
      end else begin
        chk("entry.hit", 32'(o_hit), 1);
        chk("entry.round_done", 32'(o_round_done), 0);
        chk("entry.lost", 32'(o_lost), 0);
        tick();
        chk("gap.hit", 32'(o_hit), 0);
      end
    end
  endtask

  task automatic enter_wrong(input logic [2:0] code);
    enter(code);
    chk("wrong.lost", 32'(o_lost), 1);
    chk("wrong.busy", 32'(o_busy), 0);
    chk("wrong.hit", 32'(o_hit), 0);
    chk("wrong.round_done", 32'(o_round_done), 0);
    chk("wrong.gen_stop", 32'(o_gen_stop), 0);
  endtask

  initial begin
    int wrong_at;
    logic [2:0] bad;

    use_b = 1'b0;
    max_len = 16;
    #2;
    do_reset();

    // Single round with 011, then the second capture.
    gen_value = 3'b011;
    start_game();
    capture(3'b011);
    replay(0, 0);
    enter_prefix(1);
    capture(3'b111);
    do_reset();

    // Stored 001,111; first code held through a 3-cycle stall; fail on 011.
    start_game();
    capture(3'b001);
    replay(0, 0);
    enter_prefix(1);
    capture(3'b111);
    replay(3, 0);
    enter_prefix(1);
    enter_wrong(3'b011);
    tick();
    chk("lost.sticky", 32'(o_lost), 1);

    // Restart from LOST; generator 000 is shown as 001.
    start_game();
    capture(3'b000);
    replay(0, 0);
    enter_prefix(1);

    // Random game of eight rounds, ending in a random wrong entry.
    for (int lvl = 2; lvl <= 8; lvl++) begin
      capture(3'($urandom));
      replay(0, 2);
      if (lvl < 8) begin
        enter_prefix(lvl);
      end else begin
        wrong_at = int'($urandom_range(0, lvl - 1));
        enter_prefix(wrong_at);
        bad = seq[wrong_at] ^ 3'($urandom_range(1, 7));
        enter_wrong(bad);
      end
    end

    // Reset arriving mid-replay clears everything without waiting for a clock.
    start_game();
    capture(3'b111);
    chk("pre_reset.show_valid", 32'(o_show_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    tick();
    reset = 1'b0;
    tick();
    chk_all_zero("async_release");

    // MAX_LEN=2 instance: win, then entries are ignored, then restart.
    use_b = 1'b1;
    max_len = 2;
    do_reset();
    start_game();
    capture(3'($urandom));
    replay(0, 1);
    enter_prefix(1);
    capture(3'($urandom));
    replay(0, 1);
    enter_prefix(2);
    chk("won.won", 32'(o_won), 1);
    chk("won.level", 32'(o_level), 2);
    chk("won.busy", 32'(o_busy), 0);
    chk("won.gen_stop", 32'(o_gen_stop), 0);
    player_code = seq[0] ^ 3'b010;
    player_valid = 1'b1;
    tick();
    player_valid = 1'b0;
    tick();
    chk("won_ignore.lost", 32'(o_lost), 0);
    chk("won_ignore.won", 32'(o_won), 1);
    chk("won_ignore.hit", 32'(o_hit), 0);
    chk("won_ignore.level", 32'(o_level), 2);
    start_game();
    capture(3'b011);
    replay(0, 0);
    enter_prefix(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
